// File: rtl/writeback_arbiter.sv
// Purpose: merges up to four execution-unit results per cycle onto two register-file write ports, oldest first.
// Latency: a result accepted at edge N appears on the write ports after edge N when no older entries are pending.
// Backpressure: surplus results wait in an ordered queue; stall_o asks dispatch to hold off; results that do not fit are dropped and flagged.
//
// Ports:
//   clock_i, reset_i (async, active-low), flushBack_i (sync flush, wins over everything but reset)
//   resultValid_i/resultIsWb_i [4]   per-source valid and writeback-permitted (bit0 arithA .. bit3 lsB)
//   resultAddr_i [20], resultData_i [64]   per-source 5-bit address / 16-bit data, source n in slice n
//   wrEnA_o/wrAddrA_o/wrDataA_o, wrEnB_o/wrAddrB_o/wrDataB_o   registered write ports (A = older)
//   stall_o, pending_o   registered back-pressure and queue occupancy
//   overflow_o   sticky drop indicator, cleared only by reset
module writeback_arbiter #(
  parameter int QUEUE_DEPTH = 8,
  parameter int STALL_LEVEL = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flushBack_i,
  input  logic [3:0]  resultValid_i,
  input  logic [3:0]  resultIsWb_i,
  input  logic [19:0] resultAddr_i,
  input  logic [63:0] resultData_i,
  output logic        wrEnA_o,
  output logic [4:0]  wrAddrA_o,
  output logic [15:0] wrDataA_o,
  output logic        wrEnB_o,
  output logic [4:0]  wrAddrB_o,
  output logic [15:0] wrDataB_o,
  output logic        stall_o,
  output logic [3:0]  pending_o,
  output logic        overflow_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  // Scratch arithmetic width: must hold count + 4 new results.
  localparam int NW = CW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wb_entry_t;

  wb_entry_t      mem [QUEUE_DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  logic [3:0]     accepted;
  wb_entry_t      src_ent  [4];
  wb_entry_t      new_ent  [4];
  wb_entry_t      push_ent [4];
  wb_entry_t      q_head;
  wb_entry_t      q_next;
  wb_entry_t      sel_a;
  wb_entry_t      sel_b;
  logic           sel_a_vld;
  logic           sel_b_vld;
  logic           conflict;
  logic           dropped;
  logic [NW-1:0]  cnt;
  logic [NW-1:0]  n_new;
  logic [NW-1:0]  popped;
  logic [NW-1:0]  new_slots;
  logic [NW-1:0]  new_written;
  logic [NW-1:0]  remaining;
  logic [NW-1:0]  free_slots;
  logic [NW-1:0]  pushed;
  logic [NW-1:0]  next_cnt;

  always_comb begin
    accepted = resultValid_i & resultIsWb_i;
    for (int i = 0; i < 4; i++) begin
      src_ent[i].addr = resultAddr_i[5*i +: 5];
      src_ent[i].data = resultData_i[16*i +: 16];
      new_ent[i]      = '0;
      push_ent[i]     = '0;
    end

    // Compact accepted inputs into age order (lowest source index first).
    n_new = '0;
    for (int i = 0; i < 4; i++) begin
      if (accepted[i]) begin
        for (int s = 0; s < 4; s++) begin
          if (NW'(s) == n_new) new_ent[s] = src_ent[i];
        end
        n_new = n_new + NW'(1);
      end
    end

    cnt         = {1'b0, count};
    popped      = (cnt >= NW'(2)) ? NW'(2) : cnt;
    new_slots   = NW'(2) - popped;
    new_written = (n_new < new_slots) ? n_new : new_slots;
    remaining   = n_new - new_written;
    free_slots  = NW'(QUEUE_DEPTH) - cnt + popped;
    pushed      = (remaining < free_slots) ? remaining : free_slots;
    dropped     = remaining > free_slots;
    next_cnt    = cnt - popped + pushed;

    // Queue entries are always older than this cycle's inputs.
    q_head    = mem[head];
    q_next    = mem[head + PW'(1)];
    sel_a_vld = (cnt + n_new) >= NW'(1);
    sel_b_vld = (cnt + n_new) >= NW'(2);
    sel_a     = (cnt >= NW'(1)) ? q_head : new_ent[0];
    if (cnt >= NW'(2))      sel_b = q_next;
    else if (cnt == NW'(1)) sel_b = new_ent[0];
    else                    sel_b = new_ent[1];

    // The younger write wins a same-address pair; the older one is retired unwritten.
    conflict = sel_a_vld && sel_b_vld && (sel_a.addr == sel_b.addr);

    // Leftover inputs (those not sent to a port) go to the tail in age order.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (NW'(i) == new_written + NW'(j)) push_ent[j] = new_ent[i];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      wrEnA_o    <= 1'b0;
      wrAddrA_o  <= '0;
      wrDataA_o  <= '0;
      wrEnB_o    <= 1'b0;
      wrAddrB_o  <= '0;
      wrDataB_o  <= '0;
      stall_o    <= 1'b0;
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else if (flushBack_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wrEnA_o   <= 1'b0;
      wrEnB_o   <= 1'b0;
      stall_o   <= 1'b0;
      pending_o <= '0;
    end else begin
      head      <= head + popped[PW-1:0];
      tail      <= tail + pushed[PW-1:0];
      count     <= next_cnt[CW-1:0];
      wrEnA_o   <= sel_a_vld && !conflict;
      wrEnB_o   <= sel_b_vld;
      if (sel_a_vld) begin
        wrAddrA_o <= sel_a.addr;
        wrDataA_o <= sel_a.data;
      end
      if (sel_b_vld) begin
        wrAddrB_o <= sel_b.addr;
        wrDataB_o <= sel_b.data;
      end
      stall_o   <= next_cnt > NW'(QUEUE_DEPTH - STALL_LEVEL);
      pending_o <= 4'(next_cnt);
      if (dropped) overflow_o <= 1'b1;
    end
  end

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clock_i) begin
    if (!flushBack_i) begin
      for (int j = 0; j < 4; j++) begin
        if (NW'(j) < pushed) mem[tail + PW'(j)] <= push_ent[j];
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int QD = 8;
  localparam int SL = 4;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        flushBack_i;
  logic [3:0]  resultValid_i;
  logic [3:0]  resultIsWb_i;
  logic [19:0] resultAddr_i;
  logic [63:0] resultData_i;
  logic        wrEnA_o;
  logic [4:0]  wrAddrA_o;
  logic [15:0] wrDataA_o;
  logic        wrEnB_o;
  logic [4:0]  wrAddrB_o;
  logic [15:0] wrDataB_o;
  logic        stall_o;
  logic [3:0]  pending_o;
  logic        overflow_o;

  writeback_arbiter #(.QUEUE_DEPTH(QD), .STALL_LEVEL(SL)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .flushBack_i   (flushBack_i),
    .resultValid_i (resultValid_i),
    .resultIsWb_i  (resultIsWb_i),
    .resultAddr_i  (resultAddr_i),
    .resultData_i  (resultData_i),
    .wrEnA_o       (wrEnA_o),
    .wrAddrA_o     (wrAddrA_o),
    .wrDataA_o     (wrDataA_o),
    .wrEnB_o       (wrEnB_o),
    .wrAddrB_o     (wrAddrB_o),
    .wrDataB_o     (wrDataB_o),
    .stall_o       (stall_o),
    .pending_o     (pending_o),
    .overflow_o    (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fl;
    logic [3:0]  vld;
    logic [3:0]  wb;
    logic [19:0] addr;
    logic [63:0] data;
    logic        en_a;
    logic [4:0]  a_a;
    logic [15:0] d_a;
    logic        en_b;
    logic [4:0]  a_b;
    logic [15:0] d_b;
    logic [3:0]  pend;
    logic        stall;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } ent_t;

  // Reference model state: the pending queue as a plain ordered list.
  ent_t        mq[$];
  logic        m_ovf;
  logic        e_en_a, e_en_b, e_stall;
  logic [4:0]  e_a_a, e_a_b;
  logic [15:0] e_d_a, e_d_b;
  logic [3:0]  e_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic en_a, input logic [4:0] a_a,
                            input logic [15:0] d_a, input logic en_b, input logic [4:0] a_b,
                            input logic [15:0] d_b, input logic [3:0] pend, input logic stall,
                            input logic ovf);
    chk({tag, ".wrEnA"}, 32'(wrEnA_o), 32'(en_a));
    if (en_a) begin
      chk({tag, ".wrAddrA"}, 32'(wrAddrA_o), 32'(a_a));
      chk({tag, ".wrDataA"}, 32'(wrDataA_o), 32'(d_a));
    end
    chk({tag, ".wrEnB"}, 32'(wrEnB_o), 32'(en_b));
    if (en_b) begin
      chk({tag, ".wrAddrB"}, 32'(wrAddrB_o), 32'(a_b));
      chk({tag, ".wrDataB"}, 32'(wrDataB_o), 32'(d_b));
    end
    chk({tag, ".pending"}, 32'(pending_o), 32'(pend));
    chk({tag, ".stall"}, 32'(stall_o), 32'(stall));
    chk({tag, ".overflow"}, 32'(overflow_o), 32'(ovf));
  endtask

  task automatic step(input logic fl, input logic [3:0] v, input logic [3:0] w,
                      input logic [19:0] a, input logic [63:0] d);
    flushBack_i   = fl;
    resultValid_i = v;
    resultIsWb_i  = w;
    resultAddr_i  = a;
    resultData_i  = d;
    @(posedge clock_i);
    #1;
  endtask

  // Oldest-first list of candidates: queue, then accepted inputs by source index.
  task automatic model_step(input logic fl, input logic [3:0] v, input logic [3:0] w,
                            input logic [19:0] a, input logic [63:0] d);
    ent_t cand[$];
    ent_t tmp;
    int   took;
    if (fl) begin
      mq.delete();
      e_en_a = 1'b0;
      e_en_b = 1'b0;
      e_pend = '0;
      e_stall = 1'b0;
    end else begin
      cand = mq;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && w[i]) begin
          tmp.addr = a[5*i +: 5];
          tmp.data = d[16*i +: 16];
          cand.push_back(tmp);
        end
      end
      took   = (cand.size() < 2) ? cand.size() : 2;
      e_en_a = (took >= 1);
      e_en_b = (took == 2);
      if (took >= 1) begin
        e_a_a = cand[0].addr;
        e_d_a = cand[0].data;
      end
      if (took == 2) begin
        e_a_b = cand[1].addr;
        e_d_b = cand[1].data;
        if (cand[0].addr == cand[1].addr) e_en_a = 1'b0;
      end
      for (int k = 0; k < took; k++) void'(cand.pop_front());
      while (cand.size() > QD) begin
        void'(cand.pop_back());
        m_ovf = 1'b1;
      end
      mq      = cand;
      e_pend  = 4'(mq.size());
      e_stall = (mq.size() > QD - SL);
    end
  endtask

  function automatic logic [19:0] a4(input int b);
    return {5'(b + 3), 5'(b + 2), 5'(b + 1), 5'(b)};
  endfunction

  function automatic logic [63:0] d4(input int b);
    return {16'(256 + b + 3), 16'(256 + b + 2), 16'(256 + b + 1), 16'(256 + b)};
  endfunction

  vec_t tv[15];

  initial begin
    logic        fl;
    logic [3:0]  v, w;
    logic [19:0] a;
    logic [63:0] d;

    reset_i       = 1'b0;
    flushBack_i   = 1'b0;
    resultValid_i = '0;
    resultIsWb_i  = '0;
    resultAddr_i  = '0;
    resultData_i  = '0;

    tv[0]  = '{1'b0, 4'b0001, 4'b0001, 20'd3, {48'd0, 16'hBEEF},
               1'b1, 5'd3, 16'hBEEF, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 4'b0000, 4'b0000, 20'd0, 64'd0,
               1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 4'b1111, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {16'h44, 16'h33, 16'h22, 16'h11},
               1'b1, 5'd1, 16'h11, 1'b1, 5'd2, 16'h22, 4'd2, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 4'b0000, 4'b0000, 20'd0, 64'd0,
               1'b1, 5'd3, 16'h33, 1'b1, 5'd4, 16'h44, 4'd0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 4'b0011, 4'b0011, {10'd0, 5'd7, 5'd7}, {32'd0, 16'd9, 16'd5},
               1'b0, 5'd0, 16'd0, 1'b1, 5'd7, 16'd9, 4'd0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 4'b1111, 4'b0101, {5'd13, 5'd12, 5'd11, 5'd10}, {16'hD, 16'hC, 16'hB, 16'hA},
               1'b1, 5'd10, 16'hA, 1'b1, 5'd12, 16'hC, 4'd0, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 4'b1111, 4'b1111, a4(1), d4(1),
               1'b1, 5'd1, 16'h101, 1'b1, 5'd2, 16'h102, 4'd2, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 4'b1111, 4'b1111, a4(5), d4(5),
               1'b1, 5'd3, 16'h103, 1'b1, 5'd4, 16'h104, 4'd4, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 4'b1111, 4'b1111, a4(9), d4(9),
               1'b1, 5'd5, 16'h105, 1'b1, 5'd6, 16'h106, 4'd6, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 4'b1111, 4'b1111, a4(13), d4(13),
               1'b1, 5'd7, 16'h107, 1'b1, 5'd8, 16'h108, 4'd8, 1'b1, 1'b0};
    tv[10] = '{1'b0, 4'b1111, 4'b1111, a4(17), d4(17),
               1'b1, 5'd9, 16'h109, 1'b1, 5'd10, 16'h10A, 4'd8, 1'b1, 1'b1};
    tv[11] = '{1'b0, 4'b0000, 4'b0000, 20'd0, 64'd0,
               1'b1, 5'd11, 16'h10B, 1'b1, 5'd12, 16'h10C, 4'd6, 1'b1, 1'b1};
    tv[12] = '{1'b0, 4'b0000, 4'b0000, 20'd0, 64'd0,
               1'b1, 5'd13, 16'h10D, 1'b1, 5'd14, 16'h10E, 4'd4, 1'b0, 1'b1};
    tv[13] = '{1'b1, 4'b1111, 4'b1111, a4(21), d4(21),
               1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b1};
    tv[14] = '{1'b0, 4'b0000, 4'b0000, 20'd0, 64'd0,
               1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clock_i);
    #1;
    check_outs("reset", 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0);
    chk("reset.wrAddrA", 32'(wrAddrA_o), 32'd0);
    chk("reset.wrDataA", 32'(wrDataA_o), 32'd0);
    chk("reset.wrAddrB", 32'(wrAddrB_o), 32'd0);
    chk("reset.wrDataB", 32'(wrDataB_o), 32'd0);
    reset_i = 1'b1;

    // Directed vectors from an empty queue
    for (int i = 0; i < 15; i++) begin
      step(tv[i].fl, tv[i].vld, tv[i].wb, tv[i].addr, tv[i].data);
      check_outs($sformatf("vec%0d", i), tv[i].en_a, tv[i].a_a, tv[i].d_a, tv[i].en_b,
                 tv[i].a_b, tv[i].d_b, tv[i].pend, tv[i].stall, tv[i].ovf);
    end

    // Reset asserted mid-operation with a partly full queue
    for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 4'hF, a4(4 * i), d4(4 * i));
    chk("prereset.pending", 32'(pending_o), 32'd6);
    #2 reset_i = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'hF, 4'hF, a4(1), d4(1));
    check_outs("in_reset", 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0);
    reset_i = 1'b1;
    step(1'b0, 4'h0, 4'h0, 20'd0, 64'd0);
    check_outs("post_reset", 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0, 1'b0);

    // Randomized traffic against the queue model
    mq.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic dense;
      dense = ((c / 60) % 2) == 1;
      fl = ($urandom_range(0, 39) == 0);
      v  = dense ? 4'hF : 4'($urandom);
      w  = dense ? 4'($urandom | $urandom | $urandom) : 4'($urandom | $urandom);
      a  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      d  = {32'($urandom), 32'($urandom)};
      model_step(fl, v, w, a, d);
      step(fl, v, w, a, d);
      check_outs($sformatf("rand%0d", c), e_en_a, e_a_a, e_d_a, e_en_b, e_a_b, e_d_b,
                 e_pend, e_stall, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
